// File: rtl/axi_from_lite_upsize_if.sv
// Channel bundles for the AXI-Lite upstream and full AXI4 downstream of the upsizing bridge.
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport slave (
        input  aw_addr, aw_prot, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
    modport master (
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );
endinterface

interface axi_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
        output aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
        output ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );
endinterface

// File: rtl/axi_from_lite_upsize.sv
// AXI-Lite to AXI4 bridge with data upsizing: each Lite beat becomes a single-beat INCR burst
// on one lane of the wider bus; lane FIFOs remember which lane each W and R belongs to.
module axi_from_lite_upsize_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= wrap_inc(r_wptr);
            if (i_pop)  r_rptr <= wrap_inc(r_rptr);
            if (i_push && !i_pop)      r_cnt <= r_cnt + CW'(1);
            else if (!i_push && i_pop) r_cnt <= r_cnt - CW'(1);
        end
    end

    // Storage needs no reset: it is only read while the occupancy count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_cnt == '0);
endmodule

module axi_from_lite_upsize #(
    parameter int ADDR_WIDTH      = 48,
    parameter int LITE_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int ID_VALUE        = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic            clk,
    input logic            rstn,
    axi_lite_channel.slave master,
    axi_channel.master     slave
);
    localparam int RATIO = AXI_DATA_WIDTH / LITE_DATA_WIDTH;
    localparam int LO    = $clog2(LITE_DATA_WIDTH / 8);
    localparam int HI    = $clog2(AXI_DATA_WIDTH / 8);
    localparam int LW    = (HI > LO) ? HI - LO : 1;
    localparam int LSTRB = LITE_DATA_WIDTH / 8;
    localparam int ASTRB = AXI_DATA_WIDTH / 8;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDW   = $bits(slave.aw_id);

    generate
        if ($bits(master.aw_addr) != ADDR_WIDTH || $bits(slave.aw_addr) != ADDR_WIDTH) begin : g_bad_addr
            $fatal(1, "axi_from_lite_upsize: address width mismatch between ports");
        end
        if (AXI_DATA_WIDTH < LITE_DATA_WIDTH) begin : g_bad_data
            $fatal(1, "axi_from_lite_upsize: AXI_DATA_WIDTH smaller than LITE_DATA_WIDTH");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_bad_outst
            $fatal(1, "axi_from_lite_upsize: MAX_OUTSTANDING outside 1..16");
        end
    endgenerate

    function automatic logic [LW-1:0] lane_of(input logic [ADDR_WIDTH-1:0] a);
        if (RATIO == 1) return '0;
        return LW'(a >> LO);
    endfunction

    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic          w_wr_room, w_rd_room;
    logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic          w_wf_empty, w_rf_empty;
    logic [LW-1:0] w_wf_lane, w_rf_lane;

    // Reset forces the request gates shut so nothing escapes while the counters are held clear.
    assign w_wr_room = rstn & (r_wr_cnt < CW'(MAX_OUTSTANDING));
    assign w_rd_room = rstn & (r_rd_cnt < CW'(MAX_OUTSTANDING));

    assign w_aw_hs = master.aw_valid & slave.aw_ready & w_wr_room;
    assign w_w_hs  = master.w_valid & slave.w_ready & ~w_wf_empty;
    assign w_b_hs  = slave.b_valid & master.b_ready & (r_wr_cnt != '0);
    assign w_ar_hs = master.ar_valid & slave.ar_ready & w_rd_room;
    assign w_r_hs  = slave.r_valid & master.r_ready & ~w_rf_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_aw_hs && !w_b_hs)      r_wr_cnt <= r_wr_cnt + CW'(1);
            else if (!w_aw_hs && w_b_hs) r_wr_cnt <= r_wr_cnt - CW'(1);
            if (w_ar_hs && !w_r_hs)      r_rd_cnt <= r_rd_cnt + CW'(1);
            else if (!w_ar_hs && w_r_hs) r_rd_cnt <= r_rd_cnt - CW'(1);
        end
    end

    axi_from_lite_upsize_lane_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(LW)) u_wfifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_aw_hs),
        .i_data  (lane_of(master.aw_addr)),
        .i_pop   (w_w_hs),
        .o_data  (w_wf_lane),
        .o_empty (w_wf_empty)
    );

    axi_from_lite_upsize_lane_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(LW)) u_rfifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_ar_hs),
        .i_data  (lane_of(master.ar_addr)),
        .i_pop   (w_r_hs),
        .o_data  (w_rf_lane),
        .o_empty (w_rf_empty)
    );

    assign slave.aw_id     = IDW'(ID_VALUE);
    assign slave.aw_addr   = master.aw_addr;
    assign slave.aw_len    = '0;
    assign slave.aw_size   = 3'(LO);
    assign slave.aw_burst  = 2'b01;
    assign slave.aw_lock   = 1'b0;
    assign slave.aw_cache  = '0;
    assign slave.aw_prot   = master.aw_prot;
    assign slave.aw_qos    = '0;
    assign slave.aw_region = '0;
    assign slave.aw_user   = '0;
    assign slave.aw_valid  = master.aw_valid & w_wr_room;
    assign master.aw_ready = slave.aw_ready & w_wr_room;

    assign slave.ar_id     = IDW'(ID_VALUE);
    assign slave.ar_addr   = master.ar_addr;
    assign slave.ar_len    = '0;
    assign slave.ar_size   = 3'(LO);
    assign slave.ar_burst  = 2'b01;
    assign slave.ar_lock   = 1'b0;
    assign slave.ar_cache  = '0;
    assign slave.ar_prot   = master.ar_prot;
    assign slave.ar_qos    = '0;
    assign slave.ar_region = '0;
    assign slave.ar_user   = '0;
    assign slave.ar_valid  = master.ar_valid & w_rd_room;
    assign master.ar_ready = slave.ar_ready & w_rd_room;

    // A W may only leave once its AW has registered a lane, hence the one-cycle minimum wait.
    assign slave.w_data   = {RATIO{master.w_data}};
    assign slave.w_strb   = ASTRB'(master.w_strb) << (w_wf_lane * LSTRB);
    assign slave.w_last   = 1'b1;
    assign slave.w_user   = '0;
    assign slave.w_valid  = master.w_valid & ~w_wf_empty;
    assign master.w_ready = slave.w_ready & ~w_wf_empty;

    assign master.b_resp  = slave.b_resp;
    assign master.b_valid = slave.b_valid & (r_wr_cnt != '0);
    assign slave.b_ready  = master.b_ready & (r_wr_cnt != '0);

    assign master.r_data  = LITE_DATA_WIDTH'(slave.r_data >> (w_rf_lane * LITE_DATA_WIDTH));
    assign master.r_resp  = slave.r_resp;
    assign master.r_valid = slave.r_valid & ~w_rf_empty;
    assign slave.r_ready  = master.r_ready & ~w_rf_empty;
endmodule

// File: tb/tb_axi_from_lite_upsize.sv
// Directed bench for axi_from_lite_upsize (Lite 32 / AXI 64, two outstanding per direction):
// the main thread drives both sides, a monitor checks every downstream request and upstream response.
module tb_axi_from_lite_upsize;
    logic clk;
    logic rstn;
    int   cyc;
    int   chk_cnt;
    int   err_cnt;
    int   last_aw_cyc;
    int   last_w_cyc;

    logic [127:0] exp_aw_q[$];
    logic [127:0] exp_w_q[$];
    logic [127:0] exp_ar_q[$];
    logic [127:0] exp_r_q[$];
    logic [127:0] exp_b_q[$];

    axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(32)) lite ();
    axi_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1)) axi ();

    axi_from_lite_upsize #(
        .ADDR_WIDTH      (48),
        .LITE_DATA_WIDTH (32),
        .AXI_DATA_WIDTH  (64),
        .ID_VALUE        (3),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .master (lite),
        .slave  (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected request fields: id 3, len 0, size 2, INCR, everything else zero.
    function automatic logic [127:0] req_exp(input logic [47:0] addr, input logic [2:0] prot);
        return {45'd0, 4'd3, addr, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, prot, 4'd0, 4'd0, 1'b0};
    endfunction

    function automatic logic [127:0] w_exp(input logic [63:0] d, input logic [7:0] s);
        return {54'd0, 1'b1, 1'b0, s, d};
    endfunction

    function automatic logic [127:0] r_exp(input logic [1:0] resp, input logic [31:0] d);
        return {94'd0, resp, d};
    endfunction

    task automatic idle_all();
        lite.aw_valid = 1'b0; lite.w_valid = 1'b0; lite.b_ready = 1'b0;
        lite.ar_valid = 1'b0; lite.r_ready = 1'b0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b0;
        axi.ar_ready = 1'b0; axi.r_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        #4;
        if (axi.aw_valid && axi.aw_ready) begin
            last_aw_cyc = cyc;
            if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
            else check("aw_fields", {45'd0, axi.aw_id, axi.aw_addr, axi.aw_len, axi.aw_size,
                axi.aw_burst, axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_qos,
                axi.aw_region, axi.aw_user}, exp_aw_q.pop_front());
        end
        if (axi.w_valid && axi.w_ready) begin
            last_w_cyc = cyc;
            if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
            else check("w_beat", {54'd0, axi.w_last, axi.w_user, axi.w_strb, axi.w_data},
                exp_w_q.pop_front());
        end
        if (axi.ar_valid && axi.ar_ready) begin
            if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else check("ar_fields", {45'd0, axi.ar_id, axi.ar_addr, axi.ar_len, axi.ar_size,
                axi.ar_burst, axi.ar_lock, axi.ar_cache, axi.ar_prot, axi.ar_qos,
                axi.ar_region, axi.ar_user}, exp_ar_q.pop_front());
        end
        if (lite.r_valid && lite.r_ready) begin
            if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
            else check("r_beat", {94'd0, lite.r_resp, lite.r_data}, exp_r_q.pop_front());
        end
        if (lite.b_valid && lite.b_ready) begin
            if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
            else check("b_resp", {126'd0, lite.b_resp}, exp_b_q.pop_front());
        end
    end

    initial begin
        chk_cnt = 0; err_cnt = 0; last_aw_cyc = 0; last_w_cyc = 0;
        lite.aw_addr = '0; lite.aw_prot = '0; lite.w_data = '0; lite.w_strb = '0;
        lite.ar_addr = '0; lite.ar_prot = '0;
        axi.b_id = '0; axi.b_resp = '0; axi.b_user = '0;
        axi.r_id = '0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 1'b1; axi.r_user = '0;
        rstn = 1'b0;
        // Everything asserted during reset: every gated valid/ready must stay low.
        lite.aw_valid = 1'b1; lite.w_valid = 1'b1; lite.b_ready = 1'b1;
        lite.ar_valid = 1'b1; lite.r_ready = 1'b1;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1;
        axi.ar_ready = 1'b1; axi.r_valid = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check("rst_aw_valid", axi.aw_valid, 0);
        check("rst_aw_ready", lite.aw_ready, 0);
        check("rst_ar_valid", axi.ar_valid, 0);
        check("rst_ar_ready", lite.ar_ready, 0);
        check("rst_w_valid", axi.w_valid, 0);
        check("rst_w_ready", lite.w_ready, 0);
        check("rst_r_valid", lite.r_valid, 0);
        check("rst_r_ready", axi.r_ready, 0);
        check("rst_b_valid", lite.b_valid, 0);
        check("rst_b_ready", axi.b_ready, 0);
        @(negedge clk); idle_all();
        @(negedge clk); rstn = 1'b1;

        // AW and W together at lane 1: W must trail AW by exactly one cycle.
        @(negedge clk);
        lite.aw_valid = 1'b1; lite.aw_addr = 48'h1004; lite.aw_prot = 3'b010;
        lite.w_valid = 1'b1; lite.w_data = 32'hA5A5_0001; lite.w_strb = 4'hF;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
        exp_aw_q.push_back(req_exp(48'h1004, 3'b010));
        exp_w_q.push_back(w_exp(64'hA5A50001_A5A50001, 8'hF0));
        #4; check("w_wait_same_cycle", axi.w_valid, 0);
        @(negedge clk); lite.aw_valid = 1'b0;
        #4; check("w_fwd_next_cycle", axi.w_valid, 1);
        @(negedge clk);
        check("w_latency", last_w_cyc - last_aw_cyc, 1);
        lite.w_valid = 1'b0;
        axi.b_valid = 1'b1; axi.b_resp = 2'b00; lite.b_ready = 1'b1;
        exp_b_q.push_back(128'd0);

        // Orphan W and unsolicited B must never cross the bridge.
        @(negedge clk);
        lite.w_valid = 1'b1; lite.w_data = 32'hDEAD_BEEF; axi.w_ready = 1'b1;
        axi.b_valid = 1'b1; axi.b_resp = 2'b11;
        repeat (3) begin
            #4;
            check("orphan_w_valid", axi.w_valid, 0);
            check("orphan_w_ready", lite.w_ready, 0);
            check("unsol_b_valid", lite.b_valid, 0);
            @(negedge clk);
        end
        idle_all();

        // Two writes, lane 0 then lane 1 with partial strobes; B responses in order.
        lite.aw_valid = 1'b1; lite.aw_addr = 48'h2000; lite.aw_prot = 3'b000; axi.aw_ready = 1'b1;
        exp_aw_q.push_back(req_exp(48'h2000, 3'b000));
        @(negedge clk); lite.aw_addr = 48'h200C;
        exp_aw_q.push_back(req_exp(48'h200C, 3'b000));
        @(negedge clk); lite.aw_valid = 1'b0;
        lite.w_valid = 1'b1; lite.w_data = 32'h1234_5678; lite.w_strb = 4'b0011; axi.w_ready = 1'b1;
        exp_w_q.push_back(w_exp(64'h12345678_12345678, 8'h03));
        @(negedge clk); lite.w_data = 32'hCAFE_F00D; lite.w_strb = 4'b1001;
        exp_w_q.push_back(w_exp(64'hCAFEF00D_CAFEF00D, 8'h90));
        @(negedge clk); lite.w_valid = 1'b0;
        axi.b_valid = 1'b1; axi.b_resp = 2'b10; lite.b_ready = 1'b1;
        exp_b_q.push_back(128'd2);
        @(negedge clk); axi.b_resp = 2'b00;
        exp_b_q.push_back(128'd0);
        @(negedge clk); idle_all();

        // Reads to 0x2000 and 0x2004 pick opposite halves of the same wide word.
        lite.ar_valid = 1'b1; lite.ar_addr = 48'h2000; lite.ar_prot = 3'b001; axi.ar_ready = 1'b1;
        exp_ar_q.push_back(req_exp(48'h2000, 3'b001));
        exp_r_q.push_back(r_exp(2'b00, 32'h3333_4444));
        @(negedge clk); lite.ar_addr = 48'h2004;
        exp_ar_q.push_back(req_exp(48'h2004, 3'b001));
        exp_r_q.push_back(r_exp(2'b01, 32'h1111_2222));
        @(negedge clk); lite.ar_valid = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'h1111_2222_3333_4444; axi.r_resp = 2'b00; lite.r_ready = 1'b1;
        @(negedge clk); axi.r_resp = 2'b01;
        @(negedge clk); idle_all();

        // Third AR stalls at the limit until the first R retires.
        lite.ar_valid = 1'b1; lite.ar_addr = 48'h3000; lite.ar_prot = 3'b000; axi.ar_ready = 1'b1;
        exp_ar_q.push_back(req_exp(48'h3000, 3'b000));
        exp_r_q.push_back(r_exp(2'b00, 32'hCCCC_DDDD));
        @(negedge clk); lite.ar_addr = 48'h300C;
        exp_ar_q.push_back(req_exp(48'h300C, 3'b000));
        exp_r_q.push_back(r_exp(2'b00, 32'h5555_6666));
        @(negedge clk); lite.ar_addr = 48'h3010;
        exp_ar_q.push_back(req_exp(48'h3010, 3'b000));
        exp_r_q.push_back(r_exp(2'b00, 32'h7777_8888));
        #4;
        check("ar_stall_ready", lite.ar_ready, 0);
        check("ar_stall_valid", axi.ar_valid, 0);
        @(negedge clk);
        #4; check("ar_stall_hold", lite.ar_ready, 0);
        @(negedge clk);
        axi.r_valid = 1'b1; axi.r_data = 64'hAAAA_BBBB_CCCC_DDDD; axi.r_resp = 2'b00; lite.r_ready = 1'b1;
        #4; check("ar_stall_during_r", lite.ar_ready, 0);
        @(negedge clk); axi.r_valid = 1'b0;
        #4; check("ar_accept_after_r", lite.ar_ready, 1);
        @(negedge clk); lite.ar_valid = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'h5555_6666_7777_8888;
        @(negedge clk);
        @(negedge clk); idle_all();

        // R and AR handshake in the same cycle at one outstanding read.
        lite.ar_valid = 1'b1; lite.ar_addr = 48'h4004; axi.ar_ready = 1'b1;
        exp_ar_q.push_back(req_exp(48'h4004, 3'b000));
        exp_r_q.push_back(r_exp(2'b00, 32'h9999_AAAA));
        @(negedge clk); lite.ar_addr = 48'h4000;
        exp_ar_q.push_back(req_exp(48'h4000, 3'b000));
        exp_r_q.push_back(r_exp(2'b00, 32'h89AB_CDEF));
        axi.r_valid = 1'b1; axi.r_data = 64'h9999_AAAA_BBBB_CCCC; lite.r_ready = 1'b1;
        #4;
        check("same_cycle_ar_ready", lite.ar_ready, 1);
        check("same_cycle_r_ready", axi.r_ready, 1);
        @(negedge clk); lite.ar_valid = 1'b0; axi.r_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk); axi.r_data = 64'h0F0F_0F0F_F0F0_F0F0;
        #4;
        check("unsol_r_ready", axi.r_ready, 0);
        check("unsol_r_valid", lite.r_valid, 0);
        @(negedge clk); axi.r_valid = 1'b0;
        lite.ar_valid = 1'b1; lite.ar_addr = 48'h5000;
        exp_ar_q.push_back(req_exp(48'h5000, 3'b000));
        #4; check("ar_first_after_drain", lite.ar_ready, 1);
        @(negedge clk); lite.ar_addr = 48'h5004;
        exp_ar_q.push_back(req_exp(48'h5004, 3'b000));
        #4; check("ar_second_after_drain", lite.ar_ready, 1);

        // Reset with two reads in flight: their late data must stall and the counters restart.
        @(negedge clk); rstn = 1'b0;
        #4; check("rst_mid_ar_ready", lite.ar_ready, 0);
        @(negedge clk); rstn = 1'b1; lite.ar_valid = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'h1357_9BDF_2468_ACE0; lite.r_ready = 1'b1;
        repeat (2) begin
            #4;
            check("late_r_ready", axi.r_ready, 0);
            check("late_r_valid", lite.r_valid, 0);
            @(negedge clk);
        end
        axi.r_valid = 1'b0;
        lite.ar_valid = 1'b1; lite.ar_addr = 48'h6000;
        exp_ar_q.push_back(req_exp(48'h6000, 3'b000));
        exp_r_q.push_back(r_exp(2'b00, 32'h7654_3210));
        #4; check("post_rst_ar1", lite.ar_ready, 1);
        @(negedge clk); lite.ar_addr = 48'h6004;
        exp_ar_q.push_back(req_exp(48'h6004, 3'b000));
        exp_r_q.push_back(r_exp(2'b10, 32'hFEDC_BA98));
        #4; check("post_rst_ar2", lite.ar_ready, 1);
        @(negedge clk); lite.ar_valid = 1'b0;
        axi.r_valid = 1'b1; axi.r_data = 64'hFEDC_BA98_7654_3210; axi.r_resp = 2'b00;
        @(negedge clk); axi.r_resp = 2'b10;
        @(negedge clk); idle_all();

        repeat (2) @(negedge clk);
        check("aw_q_drained", exp_aw_q.size(), 0);
        check("w_q_drained", exp_w_q.size(), 0);
        check("ar_q_drained", exp_ar_q.size(), 0);
        check("r_q_drained", exp_r_q.size(), 0);
        check("b_q_drained", exp_b_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
